// File: rtl/rule_config_ctrl.sv
// ============================================================================
// Module   : rule_config_ctrl
// Purpose  : Sequences rule add/delete commands into NUM_BYTES per-byte lookup
//            tables, tracks rule occupancy and keeps each rule's key.
// Option   : LOOKUP_HOLD_EN adds lookup masking while a rule is being written.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rule_config_ctrl #(
   parameter int NUM_BYTES = 4,
   parameter int GAP       = 6
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_op,
   input  logic [5:0]              cmd_rule,
   input  logic [NUM_BYTES*8-1:0]  cmd_key,
   output logic [NUM_BYTES-1:0]    set_valid_o,
   output logic [NUM_BYTES*17-1:0] set_o,
   output logic                    done_valid,
   output logic [1:0]              done_status,
   output logic                    busy,
   output logic [63:0]             rule_bitmap
`ifdef LOOKUP_HOLD_EN
   ,
   input  logic                    key_valid_in,
   output logic                    key_valid_out,
   output logic [15:0]             drop_cnt
`endif
);

   localparam int KEY_W = NUM_BYTES * 8;
   localparam int CNT_W = (GAP > 2) ? $clog2(GAP) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CHECK = 3'd1,
      S_ISSUE = 3'd2,
      S_WAIT  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t                  state_q;
   logic                    op_q;
   logic [5:0]              rule_q;
   logic [KEY_W-1:0]        key_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [NUM_BYTES-1:0]    set_valid_q;
   logic [NUM_BYTES*17-1:0] set_q;
   logic                    done_valid_q;
   logic [1:0]              status_q;
   logic                    ready_q;
   logic                    busy_q;
   logic [63:0]             bitmap_q;
`ifdef LOOKUP_HOLD_EN
   logic                    hold_q;
`endif

   // Key store data has no reset; an entry is only read while its bitmap bit is set.
   logic [KEY_W-1:0]        key_mem [0:63];

   logic [KEY_W-1:0]        key_sel_d;
   logic [NUM_BYTES*17-1:0] set_word_d;

   assign key_sel_d = op_q ? key_q : key_mem[rule_q];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BYTES; gi = gi + 1) begin : g_slice
         assign set_word_d[gi*17 +: 17] = {op_q, key_sel_d[gi*8 +: 8], 2'b00, rule_q};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (state_q == S_DONE && status_q == 2'd0 && op_q) begin
         key_mem[rule_q] <= key_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         op_q         <= 1'b0;
         rule_q       <= 6'd0;
         key_q        <= '0;
         cnt_q        <= '0;
         set_valid_q  <= '0;
         set_q        <= '0;
         done_valid_q <= 1'b0;
         status_q     <= 2'd0;
         ready_q      <= 1'b1;
         busy_q       <= 1'b0;
         bitmap_q     <= 64'd0;
`ifdef LOOKUP_HOLD_EN
         hold_q       <= 1'b0;
`endif
      end else begin
         set_valid_q  <= '0;
         done_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (cmd_valid) begin
                  op_q    <= cmd_op;
                  rule_q  <= cmd_rule;
                  key_q   <= cmd_key;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (op_q && bitmap_q[rule_q]) begin
                  status_q     <= 2'd1;
                  done_valid_q <= 1'b1;
                  state_q      <= S_DONE;
               end else if (!op_q && !bitmap_q[rule_q]) begin
                  status_q     <= 2'd2;
                  done_valid_q <= 1'b1;
                  state_q      <= S_DONE;
               end else begin
                  status_q    <= 2'd0;
                  key_q       <= key_sel_d;
                  set_valid_q <= '1;
                  set_q       <= set_word_d;
`ifdef LOOKUP_HOLD_EN
                  hold_q      <= 1'b1;
`endif
                  state_q     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               cnt_q   <= CNT_W'(GAP - 1);
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               // Exit on the last count so DONE lands exactly GAP cycles after ISSUE.
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  done_valid_q <= 1'b1;
                  state_q      <= S_DONE;
               end
            end
            S_DONE: begin
               if (status_q == 2'd0) begin
                  bitmap_q[rule_q] <= op_q;
               end
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
`ifdef LOOKUP_HOLD_EN
               hold_q  <= 1'b0;
`endif
               state_q <= S_IDLE;
            end
            default: begin
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

`ifdef LOOKUP_HOLD_EN
   logic [15:0] drop_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         drop_q <= 16'd0;
      end else if (key_valid_in && hold_q && drop_q != 16'hFFFF) begin
         drop_q <= drop_q + 16'd1;
      end
   end

   assign key_valid_out = key_valid_in & ~hold_q;
   assign drop_cnt      = drop_q;
`else
   // Without the hold option lookups are never masked.
`endif

   assign cmd_ready   = ready_q;
   assign busy        = busy_q;
   assign set_valid_o = set_valid_q;
   assign set_o       = set_q;
   assign done_valid  = done_valid_q;
   assign done_status = status_q;
   assign rule_bitmap = bitmap_q;

endmodule

`default_nettype wire
